// File: rtl/ext_ram_loader.sv
// ---------------------------------------------------------------------------
// ext_ram_loader
//
// Boot / program-load controller for the bat_amateur CPU's shared external
// RAM port. The CPU is held in reset while a stream of 16-bit words arrives
// over a valid/ready handshake. Each word is written to consecutive RAM
// addresses starting at a latched base address. After the last word the CPU
// is released, and a new program can be loaded once the CPU reports HALT.
// The top level uses BUS_OE to tristate BUS_OUT onto the shared bus.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-high reset
//   START       single-cycle load request (honoured only in IDLE / HALTED)
//   BASE_ADDR   first RAM address, latched on an accepted START
//   LOAD_LEN    number of words to load, latched on an accepted START
//   IN_DATA     program word from the host side
//   IN_VALID    IN_DATA is valid
//   IN_READY    loader can accept a word
//   HALT        CPU halted indication
//   CPU_RST     CPU reset, 1 = CPU held in reset
//   EXT_RAM_EN  external side owns the RAM port
//   EXT_RAM_RW  1 = read (idle / safe), 0 = write strobe
//   ADDRESS     RAM address
//   BUS_OUT     data to drive onto the bus
//   BUS_OE      drive BUS_OUT onto the bus
//   WORD_COUNT  words written in the current load
//   BUSY        load in progress (WAIT_DATA through RELEASE)
//   DONE        one-cycle pulse as the CPU is released
// ---------------------------------------------------------------------------
module ext_ram_loader #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [ADDRESS_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDRESS_WIDTH-1:0] LOAD_LEN,
    input  logic [15:0]              IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     HALT,
    output logic                     CPU_RST,
    output logic                     EXT_RAM_EN,
    output logic                     EXT_RAM_RW,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    output logic [15:0]              BUS_OUT,
    output logic                     BUS_OE,
    output logic [ADDRESS_WIDTH-1:0] WORD_COUNT,
    output logic                     BUSY,
    output logic                     DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [ADDRESS_WIDTH-1:0] r_len;
    logic [ADDRESS_WIDTH-1:0] r_count;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic [15:0]              r_bus_out;
    logic                     r_in_ready;
    logic                     r_cpu_rst;
    logic                     r_ext_en;
    logic                     r_rw;
    logic                     r_bus_oe;
    logic                     r_busy;
    logic                     r_done;

    logic [ADDRESS_WIDTH-1:0] w_count_next;
    logic                     w_xfer;

    assign w_count_next = r_count + ADDRESS_WIDTH'(1);
    assign w_xfer       = IN_VALID & r_in_ready;

    // Every output is a register; the FSM sets the value an output must hold
    // in the next state at the moment it takes the transition, so the
    // outputs line up with the state they belong to without any decode.
    // DONE defaults low each cycle so it can only ever be a single pulse.
    // The write address is base + count in ADDRESS_WIDTH bits, so it wraps
    // naturally past the top of the address space.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_address  <= '0;
            r_bus_out  <= '0;
            r_in_ready <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_ext_en   <= 1'b0;
            r_rw       <= 1'b1;
            r_bus_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (START) begin
                        r_base    <= BASE_ADDR;
                        r_len     <= LOAD_LEN;
                        r_count   <= '0;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b1;
                        r_rw      <= 1'b1;
                        r_bus_oe  <= 1'b0;
                        if (LOAD_LEN == '0) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_state    <= S_WAIT_DATA;
                            r_ext_en   <= 1'b1;
                            r_in_ready <= 1'b1;
                        end
                    end else if ((r_state == S_HALTED) && !HALT) begin
                        r_state <= S_RUN;
                    end
                end

                S_WAIT_DATA: begin
                    if (w_xfer) begin
                        r_bus_out  <= IN_DATA;
                        r_address  <= r_base + r_count;
                        r_in_ready <= 1'b0;
                        r_bus_oe   <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    r_rw    <= 1'b0;
                    r_state <= S_STROBE;
                end

                S_STROBE: begin
                    r_rw     <= 1'b1;
                    r_bus_oe <= 1'b0;
                    r_count  <= w_count_next;
                    if (w_count_next == r_len) begin
                        r_ext_en <= 1'b0;
                        r_state  <= S_RELEASE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= S_WAIT_DATA;
                    end
                end

                S_RELEASE: begin
                    r_cpu_rst <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_RUN;
                end

                S_RUN: begin
                    if (HALT) begin
                        r_state <= S_HALTED;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY   = r_in_ready;
    assign CPU_RST    = r_cpu_rst;
    assign EXT_RAM_EN = r_ext_en;
    assign EXT_RAM_RW = r_rw;
    assign ADDRESS    = r_address;
    assign BUS_OUT    = r_bus_out;
    assign BUS_OE     = r_bus_oe;
    assign WORD_COUNT = r_count;
    assign BUSY       = r_busy;
    assign DONE       = r_done;

endmodule

// File: tb/tb_ext_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ext_ram_loader
//
// Bench for ext_ram_loader. Inputs are driven 1 ns after the rising edge;
// a negedge process checks the RAM port against a queue of writes the
// current load must produce (address = base + i, data = i-th word), and
// directed checks pin timing, counts and reset values.
// ---------------------------------------------------------------------------
module tb_ext_ram_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [15:0] BASE_ADDR = '0;
    logic [15:0] LOAD_LEN = '0;
    logic [15:0] IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        HALT = 1'b0;
    logic        IN_READY;
    logic        CPU_RST;
    logic        EXT_RAM_EN;
    logic        EXT_RAM_RW;
    logic [15:0] ADDRESS;
    logic [15:0] BUS_OUT;
    logic        BUS_OE;
    logic [15:0] WORD_COUNT;
    logic        BUSY;
    logic        DONE;

    int vectors = 0;
    int miscompares = 0;
    int doneCount = 0;
    int strobes = 0;

    logic [15:0] expAddr[$];
    logic [15:0] expData[$];
    logic [15:0] words[8];
    logic [15:0] lastAddr = '0;
    logic [15:0] lastData = '0;
    logic        prevRw = 1'b1;
    logic        prevOe = 1'b0;
    logic        prevEn = 1'b0;
    logic [15:0] prevAddr = '0;
    logic [15:0] prevData = '0;

    int s2d;

    ext_ram_loader #(.ADDRESS_WIDTH(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .LOAD_LEN   (LOAD_LEN),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .HALT       (HALT),
        .CPU_RST    (CPU_RST),
        .EXT_RAM_EN (EXT_RAM_EN),
        .EXT_RAM_RW (EXT_RAM_RW),
        .ADDRESS    (ADDRESS),
        .BUS_OUT    (BUS_OUT),
        .BUS_OE     (BUS_OE),
        .WORD_COUNT (WORD_COUNT),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [15:0] base, input logic [15:0] len,
                                 input logic vld, input logic [15:0] dat);
        START     = st;
        BASE_ADDR = base;
        LOAD_LEN  = len;
        IN_VALID  = vld;
        IN_DATA   = dat;
    endtask

    task automatic haltCpu();
        HALT = 1'b1;
        tick();
        tick();
    endtask

    // Runs one complete load: queues the expected writes, issues START,
    // feeds words[] as the loader accepts them (optionally stalling after
    // word stallAt), and returns the cycle count from START to DONE.
    task automatic runLoad(input logic [15:0] base, input logic [15:0] len,
                           input int stallAt, input int stallLen, output int startToDone);
        int idx;
        int t;
        int strobesStart;
        int strobesStall;
        int doneStart;
        logic xfer;
        logic sawDone;
        for (int i = 0; i < int'(len); i++) begin
            expAddr.push_back(base + 16'(i));
            expData.push_back(words[i]);
        end
        strobesStart = strobes;
        doneStart    = doneCount;
        startToDone  = -1;
        applyStimulus(1'b1, base, len, (len != 16'd0), words[0]);
        tick();
        t = 1;
        START = 1'b0;
        HALT  = 1'b0;
        BASE_ADDR = 16'h5A5A;
        LOAD_LEN  = 16'h0007;
        checkOutput("CPU held after START", CPU_RST, 1);
        checkOutput("BUSY after START", BUSY, 1);
        checkOutput("WORD_COUNT cleared on START", WORD_COUNT, 0);
        idx = 0;
        sawDone = 1'b0;
        while (!sawDone && t < 200) begin
            xfer = IN_VALID && IN_READY;
            tick();
            t++;
            if (DONE) begin
                sawDone = 1'b1;
                startToDone = t;
            end
            if (xfer) begin
                idx++;
                if (idx >= int'(len)) IN_VALID = 1'b0;
                else IN_DATA = words[idx];
                if (idx == stallAt) begin
                    IN_VALID = 1'b0;
                    strobesStall = strobes;
                    repeat (stallLen) tick();
                    t += stallLen;
                    checkOutput("stall: IN_READY", IN_READY, 1);
                    checkOutput("stall: BUS_OE", BUS_OE, 0);
                    checkOutput("stall: RW idle", EXT_RAM_RW, 1);
                    checkOutput("stall: BUSY", BUSY, 1);
                    checkOutput("stall: only pending word strobed", strobes - strobesStall, 1);
                    IN_VALID = 1'b1;
                end
            end
        end
        checkOutput("DONE within budget", sawDone, 1);
        tick();
        checkOutput("DONE single pulse", DONE, 0);
        checkOutput("CPU released", CPU_RST, 0);
        checkOutput("BUSY cleared", BUSY, 0);
        checkOutput("RAM port released", EXT_RAM_EN, 0);
        checkOutput("WORD_COUNT at end", WORD_COUNT, len);
        checkOutput("strobes in load", strobes - strobesStart, len);
        checkOutput("DONE pulses in load", doneCount - doneStart, 1);
        checkOutput("model queue drained", expAddr.size(), 0);
    endtask

    // Per-cycle checker: every write strobe must be preceded by a setup
    // cycle with identical address/data, and must match the next write the
    // model expects. The port must be quiet while waiting for data, and
    // owned by the CPU side whenever the CPU runs.
    always @(negedge CLK) begin
        if (RST) begin
            prevRw = 1'b1;
            prevOe = 1'b0;
            prevEn = 1'b0;
        end else begin
            if (IN_READY) begin
                checkOutput("quiet RW while ready", EXT_RAM_RW, 1);
                checkOutput("quiet BUS_OE while ready", BUS_OE, 0);
            end
            if (!CPU_RST) begin
                checkOutput("port free while CPU runs", EXT_RAM_EN, 0);
            end
            if (!EXT_RAM_RW) begin
                strobes++;
                checkOutput("setup before strobe", {prevRw, prevOe, prevEn}, 3'b111);
                checkOutput("strobe drives bus", {BUS_OE, EXT_RAM_EN}, 2'b11);
                checkOutput("address stable into strobe", ADDRESS, prevAddr);
                checkOutput("data stable into strobe", BUS_OUT, prevData);
                checkOutput("strobe expected by model", (expAddr.size() > 0), 1);
                if (expAddr.size() > 0) begin
                    checkOutput("strobe address", ADDRESS, expAddr.pop_front());
                    checkOutput("strobe data", BUS_OUT, expData.pop_front());
                end
                lastAddr = ADDRESS;
                lastData = BUS_OUT;
            end
            if (DONE) begin
                doneCount++;
                checkOutput("all writes done at DONE", expAddr.size(), 0);
            end
            prevRw   = EXT_RAM_RW;
            prevOe   = BUS_OE;
            prevEn   = EXT_RAM_EN;
            prevAddr = ADDRESS;
            prevData = BUS_OUT;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #3;
        RST = 1'b1;
        #1;
        checkOutput("reset CPU_RST", CPU_RST, 1);
        checkOutput("reset EN/RW/OE", {EXT_RAM_EN, EXT_RAM_RW, BUS_OE}, 3'b010);
        checkOutput("reset ADDRESS", ADDRESS, 0);
        checkOutput("reset BUS_OUT", BUS_OUT, 0);
        checkOutput("reset IN_READY", IN_READY, 0);
        checkOutput("reset WORD_COUNT", WORD_COUNT, 0);
        checkOutput("reset BUSY/DONE", {BUSY, DONE}, 2'b00);
        tick();
        RST = 1'b0;
        tick();

        // Three-word load from IDLE: 1 START cycle + 3 cycles per word + RELEASE.
        words[0] = 16'hA001; words[1] = 16'hB002; words[2] = 16'hC003;
        runLoad(16'h0010, 16'd3, -1, 0, s2d);
        checkOutput("3-word START->DONE cycles", s2d, 11);
        checkOutput("3-word last address", lastAddr, 16'h0012);
        checkOutput("3-word last data", lastData, 16'hC003);

        // START while running is ignored.
        applyStimulus(1'b1, 16'h0055, 16'd2, 1'b1, 16'h1234);
        tick();
        START = 1'b0;
        IN_VALID = 1'b0;
        tick();
        tick();
        checkOutput("RUN ignores START: CPU_RST", CPU_RST, 0);
        checkOutput("RUN ignores START: BUSY/READY", {BUSY, IN_READY}, 2'b00);
        checkOutput("RUN ignores START: WORD_COUNT", WORD_COUNT, 3);

        // HALT then HALT release returns to RUN, where START is ignored again.
        haltCpu();
        HALT = 1'b0;
        tick();
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        checkOutput("back in RUN after HALT drop", CPU_RST, 0);

        // Reload from HALTED: one word at 0x0100.
        words[0] = 16'h0F0F;
        haltCpu();
        runLoad(16'h0100, 16'd1, -1, 0, s2d);
        checkOutput("1-word START->DONE cycles", s2d, 5);
        checkOutput("1-word address", lastAddr, 16'h0100);

        // Stalled source: 8 idle cycles after word 1 delay DONE by 6 cycles.
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        haltCpu();
        runLoad(16'h0200, 16'd3, 1, 8, s2d);
        checkOutput("stalled START->DONE cycles", s2d, 17);
        checkOutput("stalled last address", lastAddr, 16'h0202);

        // Address wrap across the top of the address space.
        words[0] = 16'hD000; words[1] = 16'hD001; words[2] = 16'hD002; words[3] = 16'hD003;
        haltCpu();
        runLoad(16'hFFFE, 16'd4, -1, 0, s2d);
        checkOutput("wrap START->DONE cycles", s2d, 14);
        checkOutput("wrap last address", lastAddr, 16'h0001);
        checkOutput("wrap last data", lastData, 16'hD003);

        // Zero-length load: straight to RELEASE, then RUN.
        haltCpu();
        runLoad(16'h0700, 16'd0, -1, 0, s2d);
        checkOutput("zero-length START->DONE cycles", s2d, 2);

        // Reset asserted during the write strobe.
        words[0] = 16'h4444; words[1] = 16'h5555;
        haltCpu();
        expAddr.push_back(16'h0300); expData.push_back(16'h4444);
        expAddr.push_back(16'h0301); expData.push_back(16'h5555);
        applyStimulus(1'b1, 16'h0300, 16'd2, 1'b1, 16'h4444);
        tick();
        START = 1'b0;
        HALT  = 1'b0;
        for (int k = 0; k < 20 && EXT_RAM_RW !== 1'b0; k++) tick();
        checkOutput("reached write strobe", EXT_RAM_RW, 0);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("abort RW", EXT_RAM_RW, 1);
        checkOutput("abort CPU_RST", CPU_RST, 1);
        checkOutput("abort EN/OE/READY", {EXT_RAM_EN, BUS_OE, IN_READY}, 3'b000);
        checkOutput("abort ADDRESS/WORD_COUNT", {ADDRESS, WORD_COUNT}, 32'd0);
        checkOutput("abort BUSY/DONE", {BUSY, DONE}, 2'b00);
        expAddr.delete();
        expData.delete();
        IN_VALID = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        checkOutput("IDLE after abort", {CPU_RST, BUSY}, 2'b10);

        // Recovery: fresh load from IDLE.
        words[0] = 16'h6666;
        runLoad(16'h0400, 16'd1, -1, 0, s2d);
        checkOutput("recovery START->DONE cycles", s2d, 5);
        checkOutput("recovery address", lastAddr, 16'h0400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ext_ram_loader.md
Name: ext_ram_loader

Overview:
- Boot/program-load controller for the bat_amateur CPU's shared external RAM port.
- Holds the CPU in reset and accepts a stream of 16-bit words over a valid/ready handshake. Writes each word to RAM at consecutive addresses, then releases the CPU to run.
- Monitors HALT so a new program can be loaded after the CPU stops.
- Sits between the host/stimulus side and the bat_amateur RAM/bus pins at the top level. The top level applies tristating using BUS_OE.

Parameters:
ADDRESS_WIDTH, 16, width of RAM address, BASE_ADDR, LOAD_LEN and word counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  single-cycle request to begin a load; sampled only in IDLE or HALTED
BASE_ADDR  input  ADDRESS_WIDTH  first RAM address; latched on accepted START
LOAD_LEN  input  ADDRESS_WIDTH  number of words to load; latched on accepted START
IN_DATA  input  16  program word
IN_VALID  input  1  IN_DATA valid
IN_READY  output  1  loader can accept a word
HALT  input  1  CPU halted indication
CPU_RST  output  1  reset to CPU; 1 = held in reset
EXT_RAM_EN  output  1  external side owns the RAM port
EXT_RAM_RW  output  1  1 = read (idle/safe), 0 = write strobe
ADDRESS  output  ADDRESS_WIDTH  RAM address
BUS_OUT  output  16  data to drive onto BUS
BUS_OE  output  1  drive BUS_OUT onto BUS
WORD_COUNT  output  ADDRESS_WIDTH  words written in the current load
BUSY  output  1  load in progress (WAIT_DATA..RELEASE)
DONE  output  1  one-cycle pulse when the CPU is released

Behaviour:
- All outputs are registered.
- Reset values: CPU_RST=1, EXT_RAM_EN=0, EXT_RAM_RW=1, ADDRESS=0, BUS_OUT=0, BUS_OE=0, IN_READY=0, WORD_COUNT=0, BUSY=0, DONE=0; state=IDLE.
- RST asserted mid-load aborts immediately to the reset values. Partially written RAM is left as is.
- States: IDLE, WAIT_DATA, SETUP, STROBE, RELEASE, RUN, HALTED.
- IDLE: CPU_RST=1.
  - START=1: latch BASE_ADDR and LOAD_LEN; clear WORD_COUNT.
  - Go to WAIT_DATA, or to RELEASE if LOAD_LEN=0.
- WAIT_DATA: IN_READY=1, BUSY=1, EXT_RAM_EN=1, RW=1, BUS_OE=0.
  - Transfer occurs when IN_VALID & IN_READY. Latch IN_DATA into BUS_OUT, set ADDRESS = base + WORD_COUNT (mod 2^ADDRESS_WIDTH), then go to SETUP.
  - IN_READY drops in the cycle after the transfer.
- SETUP (1 cycle): EXT_RAM_EN=1, BUS_OE=1, RW=1; address and data stable. Next state is STROBE.
- STROBE (1 cycle): RW=0; ADDRESS, BUS_OUT and BUS_OE are unchanged.
  - Exit: WORD_COUNT increments and RW returns to 1.
  - If WORD_COUNT+1 == latched length, go to RELEASE; otherwise go to WAIT_DATA.
- Throughput: at most one word per 3 cycles. Address and data are stable for 1 cycle before and during the write strobe.
- RELEASE (1 cycle): EXT_RAM_EN=0, BUS_OE=0, CPU_RST=1. Next state is RUN.
  - Entering RUN sets CPU_RST=0 and pulses DONE=1 for one cycle.
- RUN: CPU_RST=0, EXT_RAM_EN=0. START is ignored. HALT=1 moves to HALTED.
- HALTED: CPU_RST=0, EXT_RAM_EN=0.
  - START=1 behaves as in IDLE (latch, CPU_RST=1, then WAIT_DATA or RELEASE).
  - HALT falling with no START returns to RUN.
- START outside IDLE/HALTED is ignored. BASE_ADDR and LOAD_LEN changes after latching have no effect.
- Address wrap: base + count wraps modulo 2^ADDRESS_WIDTH. There is no error flag.
- LOAD_LEN = 2^ADDRESS_WIDTH - 1 is the maximum length; every address except one is written.
- IN_VALID held low stalls indefinitely in WAIT_DATA with the RAM port quiet (RW=1, BUS_OE=0).

Test Plan:
- Reset: assert RST mid-cycle, asynchronously -> all outputs go to reset values immediately, with no clock edge needed.
- Load 3 words (BASE_ADDR=0x0010, LOAD_LEN=3, data 0xA001/0xB002/0xC003, IN_VALID always 1):
  - Each word: RW=0 strobe with ADDRESS 0x0010/0x0011/0x0012 and matching BUS_OUT.
  - Exactly 9 cycles from the first transfer to RELEASE.
  - DONE pulses once and CPU_RST falls. WORD_COUNT=3.
- Stalled source: IN_VALID low for 5 cycles between words -> stays in WAIT_DATA, no RW=0 pulse, BUS_OE=0; resumes correctly.
- Wrap: BASE_ADDR=0xFFFE, LOAD_LEN=4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- LOAD_LEN=0 -> no write strobes; RELEASE then RUN 2 cycles after START; DONE pulses once.
- HALT flow:
  - In RUN, START is ignored.
  - Raise HALT then START with BASE_ADDR=0x0100, LOAD_LEN=1 -> CPU_RST=1 the next cycle, one write at 0x0100, then the CPU is released again.
  - RST asserted during STROBE -> RW=1 and CPU_RST=1 asynchronously.
